// File: rtl/poly_sample_writer.sv
`timescale 1ns/1ps
// Consumes packed coefficient words from the rejection sampler and writes each
// polynomial (64 words of 4 coefficients) into polynomial RAM, flushing and reseeding the sampler between polys.
module poly_sample_writer #(
   parameter int SAMPLE_W       = 23,
   parameter int BUS_W          = 4,
   parameter int WORDS_PER_POLY = 64,
   parameter int ADDR_W         = 10
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start_i,
   input  logic [2:0]                sec_lvl,
   input  logic [SAMPLE_W*BUS_W-1:0] samples_i,
   input  logic                      valid_i,
   output logic                      ready_o,
   output logic                      flush_o,
   output logic                      poly_start_o,
   output logic [15:0]               nonce_o,
   output logic [2:0]                sec_lvl_o,
   output logic                      we_o,
   output logic [ADDR_W-1:0]         waddr_o,
   output logic [SAMPLE_W*BUS_W-1:0] wdata_o,
   output logic                      busy_o,
   output logic                      done_o
);

   localparam int         DATA_W    = SAMPLE_W * BUS_W;
   localparam logic [5:0] LAST_WORD = 6'(WORDS_PER_POLY - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FLUSH,
      S_LOAD,
      S_FILL,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [3:0]          poly_idx_q, poly_idx_d;
   logic [5:0]          word_idx_q, word_idx_d;
   logic [3:0]          num_poly_q, num_poly_d;
   logic [2:0]          sec_lvl_q, sec_lvl_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   waddr_q, waddr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                handshake;

   always_comb begin
      state_d    = state_q;
      poly_idx_d = poly_idx_q;
      word_idx_d = word_idx_q;
      num_poly_d = num_poly_q;
      sec_lvl_d  = sec_lvl_q;
      we_d       = 1'b0;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
      handshake  = valid_i && (state_q == S_FILL);

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               sec_lvl_d  = sec_lvl;
               poly_idx_d = 4'd0;
               word_idx_d = 6'd0;
               state_d    = S_FLUSH;
               case (sec_lvl)
                  3'd3:    num_poly_d = 4'd11;
                  3'd5:    num_poly_d = 4'd15;
                  default: num_poly_d = 4'd8;
               endcase
            end
         end
         S_FLUSH: state_d = S_LOAD;
         S_LOAD:  state_d = S_FILL;
         S_FILL: begin
            if (handshake) begin
               we_d       = 1'b1;
               waddr_d    = ADDR_W'({poly_idx_q, word_idx_q});
               wdata_d    = samples_i;
               word_idx_d = word_idx_q + 6'd1;
               // End of poly: any sampler words still pending are dropped by the next flush.
               if (word_idx_q == LAST_WORD) begin
                  word_idx_d = 6'd0;
                  if (poly_idx_q == num_poly_q - 4'd1) begin
                     state_d = S_DONE;
                  end else begin
                     poly_idx_d = poly_idx_q + 4'd1;
                     state_d    = S_FLUSH;
                  end
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         poly_idx_q <= 4'd0;
         word_idx_q <= 6'd0;
         num_poly_q <= 4'd0;
         sec_lvl_q  <= 3'd0;
         we_q       <= 1'b0;
         waddr_q    <= '0;
         wdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         poly_idx_q <= poly_idx_d;
         word_idx_q <= word_idx_d;
         num_poly_q <= num_poly_d;
         sec_lvl_q  <= sec_lvl_d;
         we_q       <= we_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
      end
   end

   assign ready_o      = (state_q == S_FILL);
   assign flush_o      = (state_q == S_FLUSH);
   assign poly_start_o = (state_q == S_LOAD);
   assign done_o       = (state_q == S_DONE);
   assign busy_o       = (state_q != S_IDLE);
   assign nonce_o      = {12'd0, poly_idx_q};
   assign sec_lvl_o    = sec_lvl_q;
   assign we_o         = we_q;
   assign waddr_o      = waddr_q;
   assign wdata_o      = wdata_q;

endmodule

// File: tb/tb_poly_sample_writer.sv
`timescale 1ns/1ps
// Randomized bench for poly_sample_writer: a negedge recorder logs DUT activity,
// and each scenario task compares the log against the expected write stream.
module tb_poly_sample_writer;
   localparam int SAMPLE_W = 23;
   localparam int BUS_W    = 4;
   localparam int DATA_W   = SAMPLE_W * BUS_W;
   localparam int ADDR_W   = 10;

   logic              clk = 1'b0;
   logic              rst_n, start_i, valid_i;
   logic [2:0]        sec_lvl;
   logic [DATA_W-1:0] samples_i;
   logic              ready_o, flush_o, poly_start_o, we_o, busy_o, done_o;
   logic [15:0]       nonce_o;
   logic [2:0]        sec_lvl_o;
   logic [ADDR_W-1:0] waddr_o;
   logic [DATA_W-1:0] wdata_o;

   always #5 clk = ~clk;

   poly_sample_writer #(
      .SAMPLE_W(SAMPLE_W), .BUS_W(BUS_W), .WORDS_PER_POLY(64), .ADDR_W(ADDR_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .sec_lvl(sec_lvl),
      .samples_i(samples_i), .valid_i(valid_i), .ready_o(ready_o),
      .flush_o(flush_o), .poly_start_o(poly_start_o), .nonce_o(nonce_o),
      .sec_lvl_o(sec_lvl_o), .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o),
      .busy_o(busy_o), .done_o(done_o)
   );

   int tests = 0;
   int fails = 0;
   logic [DATA_W-1:0] gen_data [0:1023];

   // Activity recorder; scenario tasks snapshot these before a run and diff afterwards.
   int  cyc = 0, start_cyc = 0, done_cyc = 0;
   int  n_flush = 0, n_done = 0, viol_we = 0, viol_ready = 0;
   bit  prev_hs = 1'b0;
   logic [ADDR_W-1:0] wa_q[$];
   logic [DATA_W-1:0] wd_q[$];
   logic [15:0]       nonce_q[$];
   logic [2:0]        lvl_q[$];

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (we_o === 1'b1) begin
         wa_q.push_back(waddr_o);
         wd_q.push_back(wdata_o);
      end
      if (we_o !== prev_hs) viol_we <= viol_we + 1;
      if (ready_o === 1'b1 && (busy_o !== 1'b1 || flush_o !== 1'b0 || poly_start_o !== 1'b0 || done_o !== 1'b0))
         viol_ready <= viol_ready + 1;
      if (flush_o === 1'b1) n_flush <= n_flush + 1;
      if (poly_start_o === 1'b1) begin
         nonce_q.push_back(nonce_o);
         lvl_q.push_back(sec_lvl_o);
      end
      if (done_o === 1'b1) begin
         n_done   <= n_done + 1;
         done_cyc <= cyc;
      end
      if (start_i === 1'b1 && busy_o === 1'b0 && rst_n === 1'b1) start_cyc <= cyc;
      prev_hs <= (valid_i === 1'b1) && (ready_o === 1'b1) && (rst_n === 1'b1);
   end

   function automatic int num_polys(input logic [2:0] lvl);
      if (lvl == 3'd3) return 11;
      if (lvl == 3'd5) return 15;
      return 8;
   endfunction

   task automatic fill_data(input bit incr);
      for (int k = 0; k < 1024; k++) begin
         if (incr) begin
            for (int j = 0; j < BUS_W; j++) gen_data[k][j*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(BUS_W*k + j);
         end else begin
            gen_data[k] = DATA_W'({$urandom(), $urandom(), $urandom()});
         end
      end
   endtask

   // Starts a run and feeds words until done_o, a reset injection, or the cycle budget.
   // Called and returning in the posedge+1 phase.
   task automatic drive_run(input logic [2:0] lvl, input int duty, input int restart_at,
                            input int reset_at, output int hs_total, output bit finished);
      int hs_idx = 0;
      bit restarted = 1'b0;
      finished = 1'b0;
      sec_lvl  = lvl;
      start_i  = 1'b1;
      valid_i  = 1'b0;
      @(posedge clk); #1;
      start_i = 1'b0;
      sec_lvl = 3'($urandom());
      for (int c = 0; c < 5000; c++) begin
         valid_i   = ($urandom_range(0, 99) < duty);
         samples_i = valid_i ? gen_data[hs_idx & 1023] : DATA_W'({$urandom(), $urandom(), $urandom()});
         if (hs_idx == restart_at && !restarted) begin
            start_i   = 1'b1;
            restarted = 1'b1;
         end
         if (hs_idx == reset_at) rst_n = 1'b0;
         @(negedge clk);
         if (valid_i && ready_o === 1'b1 && rst_n) hs_idx++;
         if (done_o === 1'b1 || !rst_n) finished = 1'b1;
         @(posedge clk); #1;
         start_i = 1'b0;
         if (finished) break;
      end
      valid_i  = 1'b0;
      hs_total = hs_idx;
   endtask

   task automatic test_reset();
      bit stray = 1'b0;
      rst_n = 1'b0; start_i = 1'b0; valid_i = 1'b0; sec_lvl = 3'd0; samples_i = '0;
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if ({ready_o, flush_o, poly_start_o, we_o, done_o, busy_o, nonce_o, sec_lvl_o, waddr_o, wdata_o} !== '0) begin
         fails++;
         $display("FAIL reset_outputs: got rdy=%b fl=%b ps=%b we=%b dn=%b bsy=%b nonce=%0h lvl=%0h addr=%0h data=%0h, all must be 0",
                  ready_o, flush_o, poly_start_o, we_o, done_o, busy_o, nonce_o, sec_lvl_o, waddr_o, wdata_o);
      end
      rst_n = 1'b1;
      valid_i = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (busy_o !== 1'b0 || ready_o !== 1'b0 || we_o !== 1'b0) stray = 1'b1;
         @(posedge clk); #1;
      end
      valid_i = 1'b0;
      tests++;
      if (stray) begin
         fails++;
         $display("FAIL idle_hold: activity seen without start_i, required busy/ready/we = 0");
      end
      $display("[TB] reset: outputs cleared, idle held");
   endtask

   task automatic test_full_run(input string name, input logic [2:0] lvl, input int duty, input bit incr);
      int n = num_polys(lvl);
      int hs, bad, nw, nn;
      bit fin;
      int b_w = wa_q.size(), b_n = nonce_q.size(), b_fl = n_flush, b_dn = n_done;
      int b_vw = viol_we, b_vr = viol_ready;
      fill_data(incr);
      drive_run(lvl, duty, -1, -1, hs, fin);
      nw = wa_q.size() - b_w;
      nn = nonce_q.size() - b_n;
      tests++;
      if (!fin) begin fails++; $display("FAIL %s done_timeout: no done_o within budget, hs=%0d", name, hs); end
      tests++;
      if (nw != n*64) begin fails++; $display("FAIL %s write_count: got %0d required %0d", name, nw, n*64); end
      bad = -1;
      for (int k = 0; k < nw && k < n*64; k++)
         if (wa_q[b_w+k] !== ADDR_W'(k) || wd_q[b_w+k] !== gen_data[k]) begin bad = k; break; end
      tests++;
      if (bad >= 0) begin
         fails++;
         $display("FAIL %s write_stream: write %0d got addr=%0d data=%0h required addr=%0d data=%0h",
                  name, bad, wa_q[b_w+bad], wd_q[b_w+bad], bad, gen_data[bad]);
      end
      tests++;
      if (n_flush - b_fl != n) begin fails++; $display("FAIL %s flush_count: got %0d required %0d", name, n_flush - b_fl, n); end
      bad = (nn != n) ? 0 : -1;
      for (int i = 0; i < nn && bad < 0; i++)
         if (nonce_q[b_n+i] !== 16'(i) || lvl_q[b_n+i] !== lvl) bad = i;
      tests++;
      if (bad >= 0) begin
         fails++;
         $display("FAIL %s load_pulses: %0d loads, entry %0d nonce=%0d sec_lvl_o=%0d; required %0d loads, nonce=%0d sec_lvl_o=%0d",
                  name, nn, bad, (nn > bad) ? nonce_q[b_n+bad] : 16'hffff, (nn > bad) ? lvl_q[b_n+bad] : 3'd0, n, bad, lvl);
      end
      tests++;
      if (n_done - b_dn != 1) begin fails++; $display("FAIL %s done_count: got %0d required 1", name, n_done - b_dn); end
      // Per poly: FLUSH + LOAD + 64 FILL cycles, then DONE one cycle after the last handshake.
      if (duty == 100) begin
         tests++;
         if (done_cyc - start_cyc != n*66 + 1) begin
            fails++;
            $display("FAIL %s done_cycle: got offset %0d required %0d", name, done_cyc - start_cyc, n*66 + 1);
         end
      end
      tests++;
      if (viol_we != b_vw || viol_ready != b_vr) begin
         fails++;
         $display("FAIL %s protocol: we_o/handshake errors=%0d ready_o-outside-fill=%0d required 0,0",
                  name, viol_we - b_vw, viol_ready - b_vr);
      end
      tests++;
      if (busy_o !== 1'b0) begin fails++; $display("FAIL %s idle_after_done: busy_o=%b required 0", name, busy_o); end
      $display("[TB] %s: lvl=%0d polys=%0d writes=%0d last_addr=%0d done_off=%0d",
               name, lvl, n, nw, (nw > 0) ? wa_q[wa_q.size()-1] : 0, done_cyc - start_cyc);
   endtask

   task automatic test_restart_ignored();
      int hs, bad;
      bit fin;
      int b_w = wa_q.size(), b_n = nonce_q.size(), b_dn = n_done;
      fill_data(1'b0);
      drive_run(3'd2, 100, 3*64 + 10, -1, hs, fin);
      bad = (wa_q.size() - b_w != 512) ? 0 : -1;
      for (int k = 0; k < 512 && bad < 0; k++)
         if (wa_q[b_w+k] !== ADDR_W'(k) || wd_q[b_w+k] !== gen_data[k]) bad = k;
      tests++;
      if (!fin || bad >= 0) begin
         fails++;
         $display("FAIL restart_writes: finished=%b writes=%0d first bad=%0d, required 512 in order", fin, wa_q.size() - b_w, bad);
      end
      bad = (nonce_q.size() - b_n != 8) ? 0 : -1;
      for (int i = 0; i < 8 && bad < 0; i++) if (nonce_q[b_n+i] !== 16'(i)) bad = i;
      tests++;
      if (bad >= 0) begin
         fails++;
         $display("FAIL restart_nonces: %0d loads, first bad entry %0d, required nonces 0..7", nonce_q.size() - b_n, bad);
      end
      tests++;
      if (n_done - b_dn != 1 || done_cyc - start_cyc != 529) begin
         fails++;
         $display("FAIL restart_done: done pulses=%0d offset=%0d required 1 at 529", n_done - b_dn, done_cyc - start_cyc);
      end
      $display("[TB] restart_ignored: writes=%0d done_off=%0d", wa_q.size() - b_w, done_cyc - start_cyc);
   endtask

   task automatic test_reset_midrun();
      int hs, bad, nw;
      bit fin;
      int b_w = wa_q.size();
      fill_data(1'b0);
      drive_run(3'd2, 100, -1, 2*64 + 20, hs, fin);
      tests++;
      if ({ready_o, flush_o, poly_start_o, we_o, done_o, busy_o, nonce_o, sec_lvl_o, waddr_o, wdata_o} !== '0) begin
         fails++;
         $display("FAIL midrun_reset_outputs: rdy=%b fl=%b ps=%b we=%b dn=%b bsy=%b nonce=%0d lvl=%0d addr=%0d, all must be 0",
                  ready_o, flush_o, poly_start_o, we_o, done_o, busy_o, nonce_o, sec_lvl_o, waddr_o);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      valid_i = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      valid_i = 1'b0;
      nw = wa_q.size() - b_w;
      bad = (nw != 148) ? 0 : -1;
      for (int k = 0; k < 148 && bad < 0; k++) if (wa_q[b_w+k] !== ADDR_W'(k)) bad = k;
      tests++;
      if (!fin || bad >= 0) begin
         fails++;
         $display("FAIL midrun_reset_writes: writes=%0d first bad=%0d, required exactly addresses 0..147", nw, bad);
      end
      $display("[TB] reset_midrun: writes before abort=%0d", nw);
      test_full_run("restart_after_reset", 3'd2, 100, 1'b0);
   endtask

   initial begin
      test_reset();
      test_full_run("lvl2_incr", 3'd2, 100, 1'b1);
      test_full_run("lvl3", 3'd3, 100, 1'b0);
      test_full_run("lvl5", 3'd5, 100, 1'b0);
      test_full_run("gaps_lvl2", 3'd2, 50, 1'b0);
      test_full_run("gaps_lvl5", 3'd5, 50, 1'b0);
      test_restart_ignored();
      test_reset_midrun();
      test_full_run("lvl7_invalid", 3'd7, 100, 1'b0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
